// File: rtl/sopc_bus_ic_pkg.sv
// rtl/sopc_bus_ic_pkg.sv - shared FSM encodings, default bus widths and slave region indices
package sopc_bus_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int BUS_WIDTH = 32;
    localparam int SEL_BUS   = 4;

    localparam int REGION_ROM  = 0;
    localparam int REGION_RAM  = 1;
    localparam int REGION_UART = 2;
    localparam int REGION_GPIO = 3;

endpackage

// File: rtl/sopc_bus_ic_addr_dec.sv
// rtl/sopc_bus_ic_addr_dec.sv - bus_addr_dec: top address bits to slave index with valid flag
module bus_addr_dec #(
    parameter int ADDR_W     = 32,
    parameter int SEL_W      = 4,
    parameter int NUM_SLAVES = 4
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  idx,
    output logic              valid
);

    localparam logic [SEL_W:0] SLAVE_LIMIT = NUM_SLAVES[SEL_W:0];

    // Only the region bits take part in the decode; the slave sees the full address.
    logic [ADDR_W-SEL_W-1:0] unused_low_bits;

    assign idx             = addr[ADDR_W-1 -: SEL_W];
    assign valid           = ({1'b0, idx} < SLAVE_LIMIT);
    assign unused_low_bits = addr[ADDR_W-SEL_W-1:0];

endmodule

// File: rtl/sopc_bus_ic.sv
// rtl/sopc_bus_ic.sv - single-master NUM_SLAVES-slave interconnect; SOPC_BUS_TIMEOUT_EN enables the ack timeout
module sopc_bus_ic
    import sopc_bus_ic_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = BUS_WIDTH,
    parameter int DATA_W     = BUS_WIDTH,
    parameter int SEL_W      = SEL_BUS,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_sel,
    output logic                         m_ack,
    output logic                         m_err,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [NUM_SLAVES-1:0]        s_req,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_sel,
    input  logic [NUM_SLAVES-1:0]        s_ack,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);

    state_t              state;
    state_t              state_nxt;

    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] sel_q;
    logic [SEL_W-1:0]    idx_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [SEL_W-1:0]    dec_idx;
    logic                dec_valid;

    logic                load;
    logic                done_set;
    logic                err_nxt;
    logic [DATA_W-1:0]   rdata_nxt;

    logic                sel_ack;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timeout_hit;

    bus_addr_dec #(
        .ADDR_W     (ADDR_W),
        .SEL_W      (SEL_W),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_addr_dec (
        .addr  (m_addr),
        .idx   (dec_idx),
        .valid (dec_valid)
    );

    // Only the slave latched at request time can complete the transfer.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_ack   = s_ack[i];
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        s_req = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_req[i] = (state == ST_BUSY) && (idx_q == SEL_W'(i));
        end
    end

`ifdef SOPC_BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ST_BUSY) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // Counter holds n-1 in the n-th BUSY cycle, so BUSY lasts at most TIMEOUT cycles.
    assign timeout_hit = (to_cnt == TO_LAST);
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done_set  = 1'b0;
        err_nxt   = 1'b0;
        rdata_nxt = '0;
        case (state)
            ST_IDLE: begin
                if (m_req) begin
                    load = 1'b1;
                    if (dec_valid) begin
                        state_nxt = ST_BUSY;
                    end else begin
                        state_nxt = ST_DONE;
                        done_set  = 1'b1;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // A real ack outranks a timeout expiring in the same cycle.
                if (sel_ack) begin
                    state_nxt = ST_DONE;
                    done_set  = 1'b1;
                    rdata_nxt = we_q ? '0 : sel_rdata;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                    done_set  = 1'b1;
                    err_nxt   = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                we_q    <= m_we;
                addr_q  <= m_addr;
                wdata_q <= m_wdata;
                sel_q   <= m_sel;
                idx_q   <= dec_idx;
            end
            if (done_set) begin
                err_q   <= err_nxt;
                rdata_q <= rdata_nxt;
            end
        end
    end

    assign m_ack   = (state == ST_DONE);
    assign m_err   = err_q;
    assign m_rdata = rdata_q;
    assign s_we    = we_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_sel   = sel_q;

endmodule

// File: tb/tb_sopc_bus_ic.sv
// tb/tb_sopc_bus_ic.sv - table-driven bench for sopc_bus_ic with a scripted slave responder
module tb_sopc_bus_ic;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            m_req;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_sel;
    logic            m_ack;
    logic            m_err;
    logic [DW-1:0]   m_rdata;
    logic [NS-1:0]   s_req;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_sel;
    logic [NS-1:0]   s_ack;
    logic [NS*DW-1:0] s_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] prev_rdata;
    logic        prev_err;
    int          last_ack_cyc;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          delay;
        logic [31:0] ack_data;
        logic [3:0]  exp_req;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    sopc_bus_ic #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SEL_W      (4),
        .TIMEOUT    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_sel   (m_sel),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_sel   (s_sel),
        .s_ack   (s_ack),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int  cyc_n;
        int  busy_n;
        int  idx;
        bit  done;
        @(posedge clk); #1;
        check({v.name, " idle_no_ack"}, {31'b0, m_ack}, 32'd0);
        m_req   = 1'b1;
        m_we    = v.we;
        m_addr  = v.addr;
        m_wdata = v.wdata;
        m_sel   = v.sel;
        idx     = int'(v.addr[31:28]);
        cyc_n   = 0;
        busy_n  = 0;
        done    = 1'b0;
        while (!done && cyc_n < 40) begin
            @(posedge clk); #1;
            cyc_n++;
            if (m_ack) begin
                check({v.name, " latency"}, cyc_n, v.exp_lat);
                check({v.name, " busy_cycles"}, busy_n, v.exp_lat - 1 - ((v.exp_req == 4'b0) ? 0 : 0) - ((v.exp_req == 4'b0) ? 0 : 0));
                check({v.name, " m_err"}, {31'b0, m_err}, {31'b0, v.exp_err});
                check({v.name, " m_rdata"}, m_rdata, v.exp_rdata);
                check({v.name, " s_req_done"}, {28'b0, s_req}, 32'd0);
                prev_err     = v.exp_err;
                prev_rdata   = v.exp_rdata;
                last_ack_cyc = cyc;
                done         = 1'b1;
                m_req        = 1'b0;
                s_ack        = '0;
            end else begin
                check({v.name, " s_req"}, {28'b0, s_req}, {28'b0, v.exp_req});
                check({v.name, " hold"}, {m_rdata[30:0], m_err}, {prev_rdata[30:0], prev_err});
                check({v.name, " shared"}, {31'b0, (s_we === v.we) && (s_addr === v.addr)
                      && (s_wdata === v.wdata) && (s_sel === v.sel)}, 32'd1);
                // Master side wanders mid-transfer; the bus must keep its latched copy.
                m_we    = ~v.we;
                m_addr  = ~v.addr;
                m_wdata = ~v.wdata;
                m_sel   = ~v.sel;
                s_ack   = '0;
                for (int i = 0; i < NS; i++) begin
                    s_rdata[i*DW +: DW] = (i == idx) ? v.ack_data : (32'hBAD0_0000 | i);
                end
                s_ack[(idx + 1) % NS] = 1'b1;
                if (busy_n == v.delay) s_ack[idx % NS] = 1'b1;
                busy_n++;
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s no_m_ack actual=timeout expected=ack", v.name);
            m_req = 1'b0;
            s_ack = '0;
        end
    endtask

    initial begin
        int first_ack;

        rst     = 1'b1;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_sel   = '0;
        s_ack   = '0;
        s_rdata = '0;
        prev_err   = 1'b0;
        prev_rdata = '0;

        vecs.push_back('{"rd_s1",   1'b0, 32'h1000_0004, 32'h0,         4'hF, 2,  32'hDEAD_BEEF, 4'b0010, 1'b0, 32'hDEAD_BEEF, 4});
        vecs.push_back('{"wr_s0",   1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 1, 32'hCAFE_F00D, 4'b0001, 1'b0, 32'h0,   3});
        vecs.push_back('{"dec_5",   1'b0, 32'h5000_0000, 32'h0,         4'hF, -1, 32'h0,         4'b0000, 1'b1, 32'h0,         1});
        vecs.push_back('{"rd_s0",   1'b0, 32'h0000_0ff0, 32'h0,         4'hF, 3,  32'h0BAD_F00D, 4'b0001, 1'b0, 32'h0BAD_F00D, 5});
        vecs.push_back('{"dec_f",   1'b1, 32'hF000_0008, 32'h5555_AAAA, 4'h1, -1, 32'h0,         4'b0000, 1'b1, 32'h0,         1});
        vecs.push_back('{"wr_s3",   1'b1, 32'h3000_0020, 32'h8765_4321, 4'b1100, 0, 32'h7777_7777, 4'b1000, 1'b0, 32'h0,    2});
`ifdef SOPC_BUS_TIMEOUT_EN
        vecs.push_back('{"tmo_s1",  1'b0, 32'h1000_0000, 32'h0,         4'hF, -1, 32'h1111_1111, 4'b0010, 1'b1, 32'h0,         9});
        vecs.push_back('{"ackwin",  1'b0, 32'h2000_0000, 32'h0,         4'hF, 7,  32'hA5A5_5A5A, 4'b0100, 1'b0, 32'hA5A5_5A5A, 9});
        vecs.push_back('{"after_to",1'b0, 32'h1000_0008, 32'h0,         4'hF, 0,  32'h0F0F_0F0F, 4'b0010, 1'b0, 32'h0F0F_0F0F, 2});
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst m_ack", {31'b0, m_ack}, 32'd0);
        check("rst m_err", {31'b0, m_err}, 32'd0);
        check("rst m_rdata", m_rdata, 32'd0);
        check("rst s_req", {28'b0, s_req}, 32'd0);
        check("rst shared", {s_addr[27:0], s_sel}, 32'd0);
        check("rst s_wdata_we", {s_wdata[30:0], s_we}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_txn(vecs[i]);

        // Back-to-back reads with immediate acks complete every third cycle.
        run_txn('{"b2b_s2", 1'b0, 32'h2000_0100, 32'h0, 4'hF, 0, 32'h1111_2222, 4'b0100, 1'b0, 32'h1111_2222, 2});
        first_ack = last_ack_cyc;
        run_txn('{"b2b_s3", 1'b0, 32'h3000_0ffc, 32'h0, 4'hF, 0, 32'h3333_4444, 4'b1000, 1'b0, 32'h3333_4444, 2});
        check("b2b spacing", last_ack_cyc - first_ack, 32'd3);

        // Reset while BUSY aborts the transfer without an m_ack.
        @(posedge clk); #1;
        m_req  = 1'b1;
        m_we   = 1'b1;
        m_addr = 32'h1000_0040;
        m_wdata = 32'hFEED_FACE;
        m_sel  = 4'hF;
        @(posedge clk); #1;
        check("rstbusy s_req", {28'b0, s_req}, 32'h2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstbusy s_req0", {28'b0, s_req}, 32'd0);
        check("rstbusy m_ack", {31'b0, m_ack}, 32'd0);
        check("rstbusy m_out", {m_rdata[30:0], m_err}, 32'd0);
        check("rstbusy shared", {s_addr[27:0], s_sel}, 32'd0);
        check("rstbusy wdata", {s_wdata[30:0], s_we}, 32'd0);
        rst   = 1'b0;
        m_req = 1'b0;
        prev_err   = 1'b0;
        prev_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rstbusy no_ack", {31'b0, m_ack}, 32'd0);
        end
        run_txn('{"post_rst", 1'b0, 32'h1000_0004, 32'h0, 4'hF, 1, 32'h600D_600D, 4'b0010, 1'b0, 32'h600D_600D, 3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
